kbd_mouse_sched: RTL and testbench
==================================

KBD_MOUSE_SCHED -- requirements
Module: kbd_mouse_sched

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, event FIFO depth in entries (power of two, 2..32).
REQ-002 The module SHALL have parameter KBD_TIMEOUT, default 16'd50000, the number of clk_sys cycles to wait for an acknowledge before dropping a key or OSD code.
REQ-003 The module SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port kms_level, input, 1 bit: toggles once per new event.
REQ-006 The module SHALL have port kms_type, input, 2 bits: 0 = mouse X, 1 = mouse Y, 2 = keycode, 3 = OSD key.
REQ-007 The module SHALL have port kms_data, input, 8 bits: event payload.
REQ-008 The module SHALL have port mouse_btn_in, input, 3 bits: live mouse button state.
REQ-009 The module SHALL have port kbd_data, output, 8 bits: keycode offered to the CIA keyboard serialiser.
REQ-010 The module SHALL have port kbd_valid, output, 1 bit: kbd_data is valid.
REQ-011 The module SHALL have port kbd_ack, input, 1 bit: the keycode was accepted.
REQ-012 The module SHALL have port osd_data, output, 8 bits: key offered to the OSD controller.
REQ-013 The module SHALL have port osd_valid, output, 1 bit: osd_data is valid.
REQ-014 The module SHALL have port osd_ack, input, 1 bit: the OSD key was accepted.
REQ-015 The module SHALL have port mouse_x, output, 8 bits: wrapping horizontal counter (JOYxDAT low byte).
REQ-016 The module SHALL have port mouse_y, output, 8 bits: wrapping vertical counter (JOYxDAT high byte).
REQ-017 The module SHALL have port mouse_btn, output, 3 bits: registered copy of mouse_btn_in.
REQ-018 The module SHALL have port ovf, output, 1 bit: one-cycle pulse when an event is dropped because the FIFO is full.
REQ-019 The module SHALL have port tmo, output, 1 bit: one-cycle pulse when a handshake times out.

Function
REQ-020 The module SHALL detect an event as kms_level differing from its value registered on the previous clk_sys edge.
REQ-021 On an event, the module SHALL write {kms_type, kms_data} into the FIFO on the next clock edge.
REQ-022 The FIFO SHALL use read/write pointers one bit wider than log2(DEPTH), wrapping modulo 2*DEPTH; it is full when the MSBs differ and the LSBs are equal, and empty when the pointers are equal.
REQ-023 A write to a full FIFO SHALL be discarded, the existing contents kept, and ovf pulsed; a write and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-024 The FSM SHALL have the states IDLE, DISPATCH, KBD_WAIT and OSD_WAIT.
REQ-025 IDLE: when the FIFO is not empty, the module SHALL pop the head into head registers and go to DISPATCH.
REQ-026 DISPATCH, type 0: mouse_x <= mouse_x + kms_data, modulo 256 (a signed delta wraps naturally); then IDLE.
REQ-027 DISPATCH, type 1: mouse_y <= mouse_y + kms_data, modulo 256; then IDLE.
REQ-028 DISPATCH, type 2: the module SHALL load kbd_data, set kbd_valid, clear the timer and go to KBD_WAIT.
REQ-029 DISPATCH, type 3: the module SHALL do the same using osd_data/osd_valid and go to OSD_WAIT.
REQ-030 KBD_WAIT/OSD_WAIT: the module SHALL hold data and valid stable until the matching ack is sampled high; valid SHALL drop on the same edge and the FSM SHALL return to IDLE.
REQ-031 The timer SHALL increment every cycle in a wait state; on reaching KBD_TIMEOUT-1 without an ack, the module SHALL drop valid, pulse tmo and return to IDLE.
REQ-032 If the ack and the timeout coincide, the ack SHALL win and tmo SHALL NOT pulse.
REQ-033 An ack while not in the matching wait state SHALL be ignored.
REQ-034 Latency from an empty FIFO with the FSM in IDLE: a level toggle sampled at edge n SHALL give a FIFO write at n+1, a pop at n+2, and a mouse update or valid assertion at n+3.
REQ-035 Events SHALL be processed strictly in arrival order; mouse events are not reordered ahead of pending keys.
REQ-036 mouse_btn SHALL follow mouse_btn_in with one cycle of latency, independent of the FSM.

Reset
REQ-037 Asserting reset SHALL asynchronously clear the FIFO pointers, the FSM (to IDLE), the timer, kbd_valid, osd_valid, ovf and tmo, and set kbd_data, osd_data, mouse_x, mouse_y and mouse_btn to 0.
REQ-038 On release of reset, the registered level SHALL take kms_level on the first edge, so that no spurious event is generated.
REQ-039 A reset during KBD_WAIT or OSD_WAIT SHALL abandon the handshake with valid low and SHALL NOT pulse tmo.

Structure
REQ-040 The event-type encodings (MS_X=0, MS_Y=1, KEY=2, OSD=3) and the FSM state encoding SHALL live in a shared package, kms_pkg.
REQ-041 The FIFO SHALL be a separate sub-module, kms_fifo, parameterised by DEPTH and width 10.

Verification
REQ-042 Reset, then toggle kms_level with type 0, data 8'h05, then type 0, data 8'hFB -> mouse_x is 5 at edge n+3, then 0.
REQ-043 Keycode 8'h45, with kbd_ack asserted 10 cycles after kbd_valid -> kbd_data is 45 and stable, kbd_valid drops on the ack edge, and tmo stays 0.
REQ-044 Keycode with no ack and KBD_TIMEOUT=20 -> kbd_valid is high for exactly 20 cycles, tmo pulses once, and the next queued event dispatches.
REQ-045 Hold kbd_ack low and push 10 events with DEPTH=8 -> after one event is popped and 7 remain queued plus 1 more, ovf pulses for each drop, and the survivors are delivered in order.
REQ-046 Push type 1, data 8'h80 onto mouse_y=8'h90 -> mouse_y becomes 8'h10 (wrap).
REQ-047 Assert reset mid-KBD_WAIT -> kbd_valid is low immediately (asynchronously), the FIFO is empty, and no event is seen after release with kms_level held.

Source files
------------

// File: rtl/kms_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kms_pkg
//  Purpose  : Shared types for the keyboard/mouse event scheduler: event-type
//             encodings, scheduler state encoding and the FIFO entry layout.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package kms_pkg;

  // Width of one queued event: 2-bit type followed by 8-bit payload.
  localparam int unsigned c_ENTRY_W = 10;

  typedef enum logic [1:0] {
    MS_X = 2'd0,
    MS_Y = 2'd1,
    KEY  = 2'd2,
    OSD  = 2'd3
  } kms_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    KBD_WAIT = 2'd2,
    OSD_WAIT = 2'd3
  } kms_state_e;

  typedef struct packed {
    kms_type_e  ev_type;
    logic [7:0] data;
  } kms_entry_t;

endpackage
`default_nettype wire

// File: rtl/kms_if.sv
`default_nettype none
// ============================================================================
//  Module   : kms_if
//  Purpose  : Bundles the event input, the keyboard/OSD handshakes, the mouse
//             counters and the status pulses of kbd_mouse_sched.
//  Ports    : kms_level/kms_type/kms_data/mouse_btn_in  - event source
//             kbd_data/kbd_valid/kbd_ack                - CIA keyboard side
//             osd_data/osd_valid/osd_ack                - OSD controller side
//             mouse_x/mouse_y/mouse_btn                 - mouse state
//             ovf/tmo                                   - status pulses
//             modport slave  : the scheduler
//             modport master : the environment driving it
//  Revision : 1.0 - initial release
// ============================================================================
interface kms_if;
  logic       kms_level;
  logic [1:0] kms_type;
  logic [7:0] kms_data;
  logic [2:0] mouse_btn_in;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ack;
  logic [7:0] osd_data;
  logic       osd_valid;
  logic       osd_ack;
  logic [7:0] mouse_x;
  logic [7:0] mouse_y;
  logic [2:0] mouse_btn;
  logic       ovf;
  logic       tmo;

  modport slave (
    input  kms_level, kms_type, kms_data, mouse_btn_in, kbd_ack, osd_ack,
    output kbd_data, kbd_valid, osd_data, osd_valid,
           mouse_x, mouse_y, mouse_btn, ovf, tmo
  );

  modport master (
    output kms_level, kms_type, kms_data, mouse_btn_in, kbd_ack, osd_ack,
    input  kbd_data, kbd_valid, osd_data, osd_valid,
           mouse_x, mouse_y, mouse_btn, ovf, tmo
  );
endinterface
`default_nettype wire

// File: rtl/kms_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kms_fifo
//  Purpose  : Synchronous event FIFO with wrap-bit pointers. A write into a
//             full FIFO is discarded (drop pulses) unless a pop happens in
//             the same cycle, in which case both succeed.
//  Ports    : clk_sys, reset (async, active-high)
//             wr_en/wr_data   - push side
//             rd_en/rd_data   - pop side (rd_data shows the head, fall-through)
//             empty           - no entries
//             drop            - a write was discarded this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module kms_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  wire logic             clk_sys,
  input  wire logic             reset,
  input  wire logic             wr_en,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             rd_en,
  output logic      [WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  drop
);

  localparam int unsigned c_AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic w_full;
  logic w_do_rd;
  logic w_do_wr;

  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_rd = rd_en & ~empty;
  // A simultaneous pop frees the slot the write lands in.
  assign w_do_wr = wr_en & (~w_full | w_do_rd);
  assign drop    = wr_en & w_full & ~w_do_rd;
  assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_sys) begin
    if (w_do_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/kbd_mouse_sched.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_mouse_sched
//  Purpose  : Captures level-toggle events from the host, queues them in
//             arrival order and dispatches them: mouse deltas update the
//             wrapping X/Y counters, keycodes and OSD keys are offered on a
//             valid/ack handshake with a timeout.
//  Ports    : clk_sys  - single clock
//             reset    - asynchronous, active-high
//             bus      - kms_if.slave (event input, handshakes, mouse state,
//                        ovf/tmo status pulses)
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_mouse_sched
  import kms_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] KBD_TIMEOUT = 16'd50000
) (
  input wire logic clk_sys,
  input wire logic reset,
  kms_if.slave     bus
);

  localparam logic [15:0] c_TMO_LAST = KBD_TIMEOUT - 16'd1;

  // ---------------------------------------------------------------- capture
  // r_armed keeps the first edge after reset from comparing against the
  // reset value of r_level, so a high kms_level is not seen as an event.
  logic                 r_armed;
  logic                 r_level;
  logic                 r_evt_v;
  logic [c_ENTRY_W-1:0] r_evt_data;
  logic                 w_event;

  assign w_event = r_armed & (bus.kms_level ^ r_level);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_level    <= 1'b0;
      r_evt_v    <= 1'b0;
      r_evt_data <= '0;
    end else begin
      r_armed    <= 1'b1;
      r_level    <= bus.kms_level;
      r_evt_v    <= w_event;
      r_evt_data <= {bus.kms_type, bus.kms_data};
    end
  end

  // ------------------------------------------------------------------- fifo
  logic [c_ENTRY_W-1:0] w_fifo_rd;
  logic                 w_empty;
  logic                 w_drop;
  logic                 w_pop;

  kms_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_en   (r_evt_v),
    .wr_data (r_evt_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd),
    .empty   (w_empty),
    .drop    (w_drop)
  );

  // -------------------------------------------------------------- scheduler
  kms_state_e r_state,     w_state_nxt;
  kms_entry_t r_head,      w_head_nxt;
  logic [15:0] r_timer,    w_timer_nxt;
  logic [7:0]  r_kbd_data, w_kbd_data_nxt;
  logic        r_kbd_valid, w_kbd_valid_nxt;
  logic [7:0]  r_osd_data, w_osd_data_nxt;
  logic        r_osd_valid, w_osd_valid_nxt;
  logic [7:0]  r_mouse_x,  w_mouse_x_nxt;
  logic [7:0]  r_mouse_y,  w_mouse_y_nxt;
  logic        r_tmo,      w_tmo_nxt;
  logic        r_ovf;
  logic [2:0]  r_mouse_btn;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_timer     <= '0;
      r_kbd_data  <= '0;
      r_kbd_valid <= 1'b0;
      r_osd_data  <= '0;
      r_osd_valid <= 1'b0;
      r_mouse_x   <= '0;
      r_mouse_y   <= '0;
      r_tmo       <= 1'b0;
      r_ovf       <= 1'b0;
      r_mouse_btn <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_head_nxt;
      r_timer     <= w_timer_nxt;
      r_kbd_data  <= w_kbd_data_nxt;
      r_kbd_valid <= w_kbd_valid_nxt;
      r_osd_data  <= w_osd_data_nxt;
      r_osd_valid <= w_osd_valid_nxt;
      r_mouse_x   <= w_mouse_x_nxt;
      r_mouse_y   <= w_mouse_y_nxt;
      r_tmo       <= w_tmo_nxt;
      r_ovf       <= w_drop;
      r_mouse_btn <= bus.mouse_btn_in;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_head_nxt      = r_head;
    w_timer_nxt     = r_timer;
    w_kbd_data_nxt  = r_kbd_data;
    w_kbd_valid_nxt = r_kbd_valid;
    w_osd_data_nxt  = r_osd_data;
    w_osd_valid_nxt = r_osd_valid;
    w_mouse_x_nxt   = r_mouse_x;
    w_mouse_y_nxt   = r_mouse_y;
    w_tmo_nxt       = 1'b0;
    w_pop           = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_head_nxt  = kms_entry_t'(w_fifo_rd);
          w_state_nxt = DISPATCH;
        end
      end

      DISPATCH: begin
        w_state_nxt = IDLE;
        case (r_head.ev_type)
          MS_X: w_mouse_x_nxt = r_mouse_x + r_head.data;
          MS_Y: w_mouse_y_nxt = r_mouse_y + r_head.data;
          KEY: begin
            w_kbd_data_nxt  = r_head.data;
            w_kbd_valid_nxt = 1'b1;
            w_timer_nxt     = '0;
            w_state_nxt     = KBD_WAIT;
          end
          OSD: begin
            w_osd_data_nxt  = r_head.data;
            w_osd_valid_nxt = 1'b1;
            w_timer_nxt     = '0;
            w_state_nxt     = OSD_WAIT;
          end
          default: w_state_nxt = IDLE;
        endcase
      end

      // The ack is tested first so a coinciding timeout never pulses tmo.
      KBD_WAIT: begin
        if (bus.kbd_ack) begin
          w_kbd_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else if (r_timer == c_TMO_LAST) begin
          w_kbd_valid_nxt = 1'b0;
          w_tmo_nxt       = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end

      OSD_WAIT: begin
        if (bus.osd_ack) begin
          w_osd_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else if (r_timer == c_TMO_LAST) begin
          w_osd_valid_nxt = 1'b0;
          w_tmo_nxt       = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.kbd_data  = r_kbd_data;
  assign bus.kbd_valid = r_kbd_valid;
  assign bus.osd_data  = r_osd_data;
  assign bus.osd_valid = r_osd_valid;
  assign bus.mouse_x   = r_mouse_x;
  assign bus.mouse_y   = r_mouse_y;
  assign bus.mouse_btn = r_mouse_btn;
  assign bus.ovf       = r_ovf;
  assign bus.tmo       = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_kbd_mouse_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbd_mouse_sched
//  Purpose  : Self-checking bench for kbd_mouse_sched. Stimulus feeds a
//             reference model that predicts the ordered sequence of dispatch
//             results; a monitor pops and compares each observed dispatch.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_mouse_sched;
  import kms_pkg::*;

  localparam int          TB_DEPTH   = 8;
  localparam logic [15:0] TB_TIMEOUT = 16'd20;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  kms_if bus();

  always #5 clk_sys = ~clk_sys;

  kbd_mouse_sched #(
    .DEPTH       (TB_DEPTH),
    .KBD_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] t;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ovf_cnt = 0, exp_ovf = 0;
  int   tmo_cnt = 0, exp_tmo = 0;
  logic [7:0] mx = 8'd0, my = 8'd0;
  bit   resp_en = 1'b0;
  int   resp_fixed = -1;
  bit   btn_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: results are the running mouse sums or the offered codes,
  // produced strictly in the order events were accepted.
  task automatic model_apply(input logic [1:0] t, input logic [7:0] d);
    case (t)
      2'd0: begin mx = mx + d; sb.push_back('{t, mx}); end
      2'd1: begin my = my + d; sb.push_back('{t, my}); end
      default: sb.push_back('{t, d});
    endcase
  endtask

  task automatic send_event(input logic [1:0] t, input logic [7:0] d, input bit drop);
    @(negedge clk_sys);
    bus.kms_type  = t;
    bus.kms_data  = d;
    bus.kms_level = ~bus.kms_level;
    if (drop) exp_ovf++;
    else model_apply(t, d);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 2000 && (sb.size() != 0 || bus.kbd_valid || bus.osd_valid); i++)
      @(negedge clk_sys);
    check("drain", 32'(sb.size() == 0 && !bus.kbd_valid && !bus.osd_valid), 32'd1);
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic wait_valid(input bit osd);
    int i;
    for (i = 0; i < 60 && !(osd ? bus.osd_valid : bus.kbd_valid); i++)
      @(negedge clk_sys);
    check("valid_rise", 32'(osd ? bus.osd_valid : bus.kbd_valid), 32'd1);
  endtask

  task automatic observe(input logic [1:0] t, input logic [7:0] v);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_dispatch: got type %0d value %0h, expected nothing", t, v);
    end else begin
      e = sb.pop_front();
      check("dispatch_type", 32'(t), 32'(e.t));
      check("dispatch_value", 32'(v), 32'(e.v));
    end
  endtask

  // Monitor: every change of a mouse counter or rising valid is one dispatch.
  initial begin
    logic [7:0] p_x, p_y, p_kd, p_od;
    logic       p_kv, p_ov;
    p_x = 0; p_y = 0; p_kd = 0; p_od = 0; p_kv = 0; p_ov = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (bus.ovf) ovf_cnt++;
        if (bus.tmo) tmo_cnt++;
        if (bus.mouse_x !== p_x) observe(2'd0, bus.mouse_x);
        if (bus.mouse_y !== p_y) observe(2'd1, bus.mouse_y);
        if (bus.kbd_valid && !p_kv) observe(2'd2, bus.kbd_data);
        if (bus.osd_valid && !p_ov) observe(2'd3, bus.osd_data);
        if (bus.kbd_valid && p_kv) check("kbd_hold", 32'(bus.kbd_data), 32'(p_kd));
        if (bus.osd_valid && p_ov) check("osd_hold", 32'(bus.osd_data), 32'(p_od));
      end
      p_x = bus.mouse_x; p_y = bus.mouse_y;
      p_kd = bus.kbd_data; p_od = bus.osd_data;
      p_kv = bus.kbd_valid; p_ov = bus.osd_valid;
    end
  end

  // Handshake responder: acks after a delay, then checks valid dropped.
  initial begin
    bit is_kbd;
    int d;
    forever begin
      @(negedge clk_sys);
      if (resp_en && !reset && (bus.kbd_valid || bus.osd_valid)) begin
        is_kbd = bus.kbd_valid;
        d = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 12));
        repeat (d) @(negedge clk_sys);
        if (is_kbd) bus.kbd_ack = 1'b1;
        else        bus.osd_ack = 1'b1;
        @(negedge clk_sys);
        check(is_kbd ? "kbd_valid_after_ack" : "osd_valid_after_ack",
              32'(is_kbd ? bus.kbd_valid : bus.osd_valid), 32'd0);
        check("tmo_on_ack", 32'(bus.tmo), 32'd0);
        bus.kbd_ack = 1'b0;
        bus.osd_ack = 1'b0;
      end
    end
  end

  // Mouse buttons: the output must still show the previous input after a change.
  initial begin
    logic [2:0] old;
    forever begin
      @(negedge clk_sys);
      if (btn_en) begin
        old = bus.mouse_btn_in;
        bus.mouse_btn_in = 3'($urandom_range(0, 7));
        #1;
        check("mouse_btn", 32'(bus.mouse_btn), 32'(old));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.kms_level = 1'b0; bus.kms_type = 2'd0; bus.kms_data = 8'd0;
    bus.mouse_btn_in = 3'd0; bus.kbd_ack = 1'b0; bus.osd_ack = 1'b0;

    repeat (3) @(negedge clk_sys);
    check("rst_kbd_valid", 32'(bus.kbd_valid), 32'd0);
    check("rst_osd_valid", 32'(bus.osd_valid), 32'd0);
    check("rst_kbd_data",  32'(bus.kbd_data),  32'd0);
    check("rst_osd_data",  32'(bus.osd_data),  32'd0);
    check("rst_mouse_x",   32'(bus.mouse_x),   32'd0);
    check("rst_mouse_y",   32'(bus.mouse_y),   32'd0);
    check("rst_mouse_btn", 32'(bus.mouse_btn), 32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_tmo",       32'(bus.tmo),       32'd0);

    // High level across release must not produce an event.
    bus.kms_level = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);

    // Acks while idle are ignored.
    bus.kbd_ack = 1'b1; bus.osd_ack = 1'b1;
    @(negedge clk_sys);
    bus.kbd_ack = 1'b0; bus.osd_ack = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("idle_no_dispatch", 32'(bus.mouse_x | bus.mouse_y), 32'd0);

    // Latency and signed wrap on X.
    send_event(MS_X, 8'h05, 1'b0);
    repeat (3) @(negedge clk_sys);
    check("lat_before_n3", 32'(bus.mouse_x), 32'h00);
    @(negedge clk_sys);
    check("lat_at_n3", 32'(bus.mouse_x), 32'h05);
    send_event(MS_X, 8'hFB, 1'b0);
    wait_drain();
    check("x_back_to_zero", 32'(bus.mouse_x), 32'h00);

    // Y wrap: 0x90 + 0x80.
    send_event(MS_Y, 8'h90, 1'b0);
    send_event(MS_Y, 8'h80, 1'b0);
    wait_drain();
    check("y_wrap", 32'(bus.mouse_y), 32'h10);

    // Keycode acked 10 cycles after valid.
    resp_fixed = 10; resp_en = 1'b1;
    send_event(KEY, 8'h45, 1'b0);
    wait_drain();
    resp_en = 1'b0;
    check("tmo_none_after_ack", 32'(tmo_cnt), 32'd0);

    // Keycode with no ack times out; the queued mouse event follows.
    send_event(KEY, 8'h5A, 1'b0);
    send_event(MS_X, 8'h03, 1'b0);
    wait_valid(1'b0);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (!bus.kbd_valid) break;
      cnt++;
    end
    check("timeout_width", 32'(cnt), 32'(TB_TIMEOUT));
    check("timeout_tmo_pulse", 32'(bus.tmo), 32'd1);
    exp_tmo++;
    wait_drain();
    check("tmo_count_once", 32'(tmo_cnt), 32'(exp_tmo));

    // A keyboard ack must not complete an OSD handshake.
    send_event(OSD, 8'h3C, 1'b0);
    wait_valid(1'b1);
    @(negedge clk_sys);
    bus.kbd_ack = 1'b1;
    @(negedge clk_sys);
    bus.kbd_ack = 1'b0;
    check("osd_ignores_kbd_ack", 32'(bus.osd_valid), 32'd1);
    resp_fixed = 3; resp_en = 1'b1;
    wait_drain();
    resp_en = 1'b0;

    // Burst of 10 keys with ack held off: one in service, DEPTH queued, rest dropped.
    for (int i = 0; i < 10; i++)
      send_event(KEY, 8'(8'h10 + i), i > TB_DEPTH);
    repeat (3) @(negedge clk_sys);
    check("ovf_count_burst", 32'(ovf_cnt), 32'(exp_ovf));
    resp_fixed = 1; resp_en = 1'b1;
    wait_drain();
    resp_en = 1'b0;

    // Reset in the middle of a keyboard handshake with a mouse event queued.
    send_event(KEY, 8'h77, 1'b0);
    send_event(MS_X, 8'h11, 1'b0);
    wait_valid(1'b0);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    check("async_rst_kbd_valid", 32'(bus.kbd_valid), 32'd0);
    check("async_rst_mouse_x", 32'(bus.mouse_x), 32'd0);
    sb.delete();
    mx = 8'd0; my = 8'd0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (12) @(negedge clk_sys);
    check("post_rst_kbd_valid", 32'(bus.kbd_valid), 32'd0);
    check("post_rst_mouse_x", 32'(bus.mouse_x), 32'd0);
    check("post_rst_no_tmo", 32'(tmo_cnt), 32'(exp_tmo));

    // Randomised traffic with a randomly delayed responder.
    resp_fixed = -1; resp_en = 1'b1; btn_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [1:0] t;
      logic [7:0] d;
      for (int w = 0; w < 500 && sb.size() >= 4; w++) @(negedge clk_sys);
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      t = 2'($urandom_range(0, 3));
      d = (t < 2) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
      send_event(t, d, 1'b0);
    end
    wait_drain();
    btn_en = 1'b0;

    check("final_ovf_count", 32'(ovf_cnt), 32'(exp_ovf));
    check("final_tmo_count", 32'(tmo_cnt), 32'(exp_tmo));
    check("final_x", 32'(bus.mouse_x), 32'(mx));
    check("final_y", 32'(bus.mouse_y), 32'(my));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
